// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, direct-mapped one-word-per-line icache filled through
// the memory controller, and JAL / 2-bit BHT next-PC prediction.
module ifetch_unit #(
  parameter int          ICACHE_IDX_W = 4,
  parameter int          BHT_IDX_W    = 6,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rs_full,
  input  logic        lsb_full,
  input  logic        rob_full,
  output logic        inst_rdy,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_pred_jump,
  output logic        mc_en,
  output logic [31:0] mc_pc,
  input  logic        mc_done,
  input  logic [31:0] mc_data,
  input  logic        rollback,
  input  logic [31:0] rollback_pc,
  input  logic        br_upd,
  input  logic [31:0] br_upd_pc,
  input  logic        br_upd_taken
);

  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int BHT_N = 1 << BHT_IDX_W;
  localparam int TAG_W = 32 - ICACHE_IDX_W - 2;

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_WAIT_MEM = 1'b1;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [0:0]         r_state;
  logic [31:0]        r_pc;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag [LINES];
  logic [31:0]        r_data [LINES];
  logic [2*BHT_N-1:0] r_bht;

  logic        r_instRdy;
  logic [31:0] r_inst;
  logic [31:0] r_instPc;
  logic        r_predJump;
  logic        r_mcEn;
  logic [31:0] r_mcPc;

  logic [ICACHE_IDX_W-1:0] w_idx;
  logic [TAG_W-1:0]        w_tag;
  logic                    w_hit;
  logic [31:0]             w_line;
  logic                    w_full;
  logic                    w_fill;
  logic [BHT_IDX_W-1:0]    w_bhtIdx;
  logic [BHT_IDX_W-1:0]    w_updIdx;
  logic [1:0]              w_updCtr;
  logic [31:0]             w_jImm;
  logic [31:0]             w_bImm;
  logic                    w_pred;
  logic [31:0]             w_nextPc;
  logic                    w_unused;

  assign w_idx    = r_pc[ICACHE_IDX_W+1:2];
  assign w_tag    = r_pc[31:ICACHE_IDX_W+2];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_line   = r_data[w_idx];
  assign w_full   = rs_full || lsb_full || rob_full;
  assign w_bhtIdx = r_pc[BHT_IDX_W+1:2];
  assign w_updIdx = br_upd_pc[BHT_IDX_W+1:2];
  assign w_updCtr = r_bht[{w_updIdx, 1'b0} +: 2];
  assign w_unused = ^{br_upd_pc[31:BHT_IDX_W+2], br_upd_pc[1:0]};

  // A rollback in the same cycle as mc_done abandons the fill.
  assign w_fill = rdy && !rollback && (r_state == S_WAIT_MEM) && mc_done;

  assign w_jImm = {{12{w_line[31]}}, w_line[19:12], w_line[20], w_line[30:21], 1'b0};
  assign w_bImm = {{20{w_line[31]}}, w_line[7], w_line[30:25], w_line[11:8], 1'b0};

  always_comb begin
    w_pred   = 1'b0;
    w_nextPc = r_pc + 32'd4;
    if (w_line[6:0] == OP_JAL) begin
      w_pred   = 1'b1;
      w_nextPc = r_pc + w_jImm;
    end else if (w_line[6:0] == OP_BRANCH && r_bht[{w_bhtIdx, 1'b1}]) begin
      w_pred   = 1'b1;
      w_nextPc = r_pc + w_bImm;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill && !rst) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= mc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_valid    <= '0;
      r_bht      <= {BHT_N{2'b01}};
      r_instRdy  <= 1'b0;
      r_inst     <= 32'h0;
      r_instPc   <= 32'h0;
      r_predJump <= 1'b0;
      r_mcEn     <= 1'b0;
      r_mcPc     <= 32'h0;
    end else if (rdy) begin
      r_instRdy <= 1'b0;
      // Counter update reads the pre-edge value, so a same-cycle prediction sees the old state.
      if (br_upd) begin
        if (br_upd_taken && w_updCtr != 2'b11) begin
          r_bht[{w_updIdx, 1'b0} +: 2] <= w_updCtr + 2'b01;
        end else if (!br_upd_taken && w_updCtr != 2'b00) begin
          r_bht[{w_updIdx, 1'b0} +: 2] <= w_updCtr - 2'b01;
        end
      end
      if (rollback) begin
        r_pc    <= rollback_pc;
        r_mcEn  <= 1'b0;
        r_state <= S_IDLE;
      end else if (r_state == S_IDLE) begin
        if (!w_hit) begin
          r_mcEn  <= 1'b1;
          r_mcPc  <= r_pc;
          r_state <= S_WAIT_MEM;
        end else if (!w_full) begin
          r_instRdy  <= 1'b1;
          r_inst     <= w_line;
          r_instPc   <= r_pc;
          r_predJump <= w_pred;
          r_pc       <= w_nextPc;
        end
      end else if (mc_done) begin
        r_valid[w_idx] <= 1'b1;
        r_mcEn         <= 1'b0;
        r_state        <= S_IDLE;
      end
    end
  end

  assign inst_rdy       = r_instRdy;
  assign inst           = r_inst;
  assign inst_pc        = r_instPc;
  assign inst_pred_jump = r_predJump;
  assign mc_en          = r_mcEn;
  assign mc_pc          = r_mcPc;

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch stage feeding the decoder. Holds the PC and a direct-mapped one-word-per-line icache. It fills misses through the memory controller and predicts next-PC using JAL decode plus a 2-bit BHT. It presents one instruction per cycle on the inst_rdy/inst/inst_pc/inst_pred_jump interface, stalls on downstream full, and redirects on ROB rollback.

Parameters:
ICACHE_IDX_W, 4, log2 of icache line count (16 lines, 1 word each; tag = pc[31:ICACHE_IDX_W+2])
BHT_IDX_W, 6, log2 of BHT entries (index = pc[BHT_IDX_W+1:2])
RESET_PC, 32'h0, PC after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; low freezes all state
rs_full  in  1  RS cannot take one more beyond any in-flight issue
lsb_full  in  1  LSB likewise
rob_full  in  1  ROB likewise
inst_rdy  out  1  instruction valid this cycle (one-cycle pulse per instruction)
inst  out  32  instruction word
inst_pc  out  32  its PC
inst_pred_jump  out  1  1 = predicted taken
mc_en  out  1  memory read request, held high until mc_done
mc_pc  out  32  word-aligned fetch address
mc_done  in  1  one-cycle pulse, mc_data valid
mc_data  in  32  fetched word
rollback  in  1  ROB misprediction/redirect
rollback_pc  in  32  redirect target
br_upd  in  1  ROB commits a conditional branch
br_upd_pc  in  32  PC of committed branch
br_upd_taken  in  1  actual outcome

Behaviour:
- Priority each edge: rst > !rdy (hold everything, outputs keep values) > rollback > normal.
- Reset: pc=RESET_PC, state=IDLE, all icache valid bits=0, all BHT counters=2'b01, inst_rdy=0, inst=0, inst_pc=0, inst_pred_jump=0, mc_en=0, mc_pc=0.
- All outputs are registered. inst_rdy defaults to 0 every edge unless set below.
- States: IDLE, WAIT_MEM.
- IDLE, hit (valid[idx] && tag match), !(rs_full||lsb_full||rob_full): next edge inst_rdy=1, inst=line, inst_pc=pc, inst_pred_jump=pred, pc=next_pc. Throughput 1 instruction/cycle on consecutive hits.
- IDLE, hit, any full: no emit, pc held.
- IDLE, miss: mc_en=1, mc_pc=pc, go WAIT_MEM. A miss is serviced regardless of full flags.
- WAIT_MEM: hold mc_en/mc_pc. On mc_done: write line (valid=1, tag, mc_data), mc_en=0, go IDLE. The instruction is emitted by the following IDLE hit (miss latency = mem latency + 2 cycles).
- Prediction on fetched word w at pc:
  - opcode 1101111 (JAL): pred=1, next_pc = pc + J-imm (sign-extended, bit0=0).
  - opcode 1100011 (branch): pred = BHT[idx][1]; next_pc = pred ? pc + B-imm : pc+4.
  - All others, including JALR: pred=0, next_pc=pc+4.
- Rollback: pc=rollback_pc, inst_rdy=0, mc_en=0, state=IDLE. An in-flight mem request is abandoned; the memory controller treats mc_en low as abort. mc_done arriving in the same cycle as rollback is ignored (no cache write). Icache contents are kept.
- BHT update (any state, including during rollback, not during rst/!rdy): on br_upd, counter at br_upd_pc index saturates up if taken, down if not (00..11, no wrap). Update and read of the same entry in one cycle: read returns the old value.
- Adders are 32-bit, wrapping at 2^32. pc[1:0] is always 0.

Test Plan:
- Reset, then rdy=1 with no fills: mc_en=1, mc_pc=0 on first edge; inst_rdy stays 0 until mc_done with mc_data=32'h00500093; two cycles later inst_rdy=1, inst=32'h00500093, inst_pc=0, pred=0; next request mc_pc=4.
- Refetch after loop-back (rollback_pc=0 with line 0 cached): inst_rdy the cycle after rollback, with no mc_en.
- JAL 32'h0080006F at pc=8: inst_pred_jump=1; the next fetch is pc=16.
- Branch at 0x20: BHT initially 01, so pred=0, next 0x24. Two br_upd_taken=1 for pc 0x20 give counter 11, so the next fetch has pred=1 and target pc+B-imm. Four not-taken updates saturate at 00.
- Rollback asserted mid WAIT_MEM, coincident with mc_done: mc_en drops, the line stays invalid, and the next mc_pc equals rollback_pc.
- Consecutive hits with rob_full pulsed high for 3 cycles: no inst_rdy in those cycles, pc unchanged, stream resumes without a gap or duplicate. rdy=0 for 2 cycles freezes all outputs.
